// File: rtl/onehot_to_binary.sv
// One-hot (10-bit) to 4-bit binary encoder feeding a DEPTH-entry output FIFO of {code, err}.
// Optional saturating illegal-word counter is enabled by defining ONEHOT_ERRCNT_EN.
module onehot_to_binary #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] onehot,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] fourBit,
  output logic       out_err,
  output logic       out_valid,
  input  logic       out_ready
`ifdef ONEHOT_ERRCNT_EN
  ,
  input  logic       err_clr,
  output logic [7:0] err_count
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [3:0]    code_mem [DEPTH];
  logic          err_mem  [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [3:0]    enc_code;
  logic          enc_err;
  logic          push;
  logic          pop;

  // Lowest set bit wins; an all-zero word falls through to 4'b1111.
  always_comb begin
    enc_code = 4'b1111;
    for (int i = 9; i >= 0; i--) begin
      if (onehot[i]) enc_code = 4'(i);
    end
    enc_err = (onehot == 10'd0) || ((onehot & (onehot - 10'd1)) != 10'd0);
  end

  // Ready comes from registered occupancy only, held low while reset is asserted.
  assign in_ready  = !reset && (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign fourBit   = code_mem[rd_ptr];
  assign out_err   = err_mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        code_mem[i] <= 4'b0000;
        err_mem[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        code_mem[wr_ptr] <= enc_code;
        err_mem[wr_ptr]  <= enc_err;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ONEHOT_ERRCNT_EN
  // Clear beats a same-cycle increment; the count sticks at 255.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_count <= 8'd0;
    else if (err_clr)
      err_count <= 8'd0;
    else if (push && enc_err && (err_count != 8'hFF))
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_onehot_to_binary.sv
// Scoreboard bench for onehot_to_binary: the driver queues hand-computed {code, err} on accept,
// and an independent monitor pops and compares whenever the DUT hands off its head entry.
module tb_onehot_to_binary;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] onehot;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] fourBit;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;
`ifdef ONEHOT_ERRCNT_EN
  logic       err_clr;
  logic [7:0] err_count;
`endif

  typedef struct packed {
    logic [3:0] code;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  onehot_to_binary #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .onehot    (onehot),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fourBit   (fourBit),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef ONEHOT_ERRCNT_EN
    ,
    .err_clr   (err_clr),
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Holds the word until accepted; the expectation is queued at the negedge before the accepting edge.
  task automatic applyStimulus(input logic [9:0] word, input logic [3:0] code, input logic err);
    bit   done = 1'b0;
    exp_t e;
    e.code   = code;
    e.err    = err;
    onehot   = word;
    in_valid = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL accept_timeout: word %b never accepted, expected acceptance", word);
    end
  endtask

  task automatic waitDrain();
    int c = 0;
    while (sb.size() != 0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    checkOutput("drain_left", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake on the output side must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("[TB] FAIL unexpected_head: got code %0d err %0d, expected no output", fourBit, out_err);
      end else begin
        e = sb.pop_front();
        checkOutput("head_code", fourBit, e.code);
        checkOutput("head_err", out_err, e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    onehot    = 10'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
`ifdef ONEHOT_ERRCNT_EN
    err_clr   = 1'b0;
`endif

    // Reset values, then ready in the first cycle after release.
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_fourBit", fourBit, 0);
    checkOutput("rst_out_err", out_err, 0);
`ifdef ONEHOT_ERRCNT_EN
    checkOutput("rst_err_count", err_count, 0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", in_ready, 1);
    checkOutput("post_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;

    // Single legal word: latency 1, popped on the following edge.
    out_ready = 1'b1;
    applyStimulus(10'b0000001000, 4'd3, 1'b0);
    checkOutput("lat1_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    checkOutput("after_pop_out_valid", out_valid, 0);

    // Illegal and edge-of-range words.
    applyStimulus(10'b0000000000, 4'd15, 1'b1);
    applyStimulus(10'b1000100000, 4'd5, 1'b1);
`ifdef ONEHOT_ERRCNT_EN
    checkOutput("err_count_two", err_count, 2);
`endif
    applyStimulus(10'b1000000000, 4'd9, 1'b0);
    applyStimulus(10'b0000000011, 4'd0, 1'b1);
    applyStimulus(10'b1111111111, 4'd0, 1'b1);
    applyStimulus(10'b0000000001, 4'd0, 1'b0);
    waitDrain();

    // Fill to DEPTH with output stalled; the third word must wait for a pop.
    out_ready = 1'b0;
    applyStimulus(10'b0000000010, 4'd1, 1'b0);
    applyStimulus(10'b0000000100, 4'd2, 1'b0);
    checkOutput("full_in_ready", in_ready, 0);
    fork
      applyStimulus(10'b0000001000, 4'd3, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          checkOutput("full_hold_in_ready", in_ready, 0);
          checkOutput("full_head_stable", fourBit, 1);
          checkOutput("full_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    waitDrain();

    // Streaming: push and pop every cycle, head never empties between words.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [9:0] w;
      w = 10'd1 << i;
      if (i > 0) checkOutput("stream_no_bubble", out_valid, 1);
      applyStimulus(w, 4'(i), 1'b0);
    end
    waitDrain();

    // Mid-operation reset with two entries buffered; old entries must never surface.
    out_ready = 1'b0;
    applyStimulus(10'b0010000000, 4'd7, 1'b0);
    applyStimulus(10'b0100000000, 4'd8, 1'b0);
    #2 reset = 1'b1;
    sb.delete();
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 0);
    checkOutput("midrst_fourBit", fourBit, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_release_in_ready", in_ready, 1);
    checkOutput("midrst_release_out_valid", out_valid, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    applyStimulus(10'b0001000000, 4'd6, 1'b0);
    waitDrain();

`ifdef ONEHOT_ERRCNT_EN
    // Saturation at 255, then clear wins over a same-cycle illegal accept.
    for (int i = 0; i < 300; i++) applyStimulus(10'b0000000000, 4'd15, 1'b1);
    checkOutput("err_count_sat", err_count, 255);
    err_clr = 1'b1;
    applyStimulus(10'b0000000101, 4'd0, 1'b1);
    err_clr = 1'b0;
    checkOutput("err_count_clr", err_count, 0);
    waitDrain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
